// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite response codes and address helpers
package axil_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int addr_lsb(input int strb_width);
        return $clog2(strb_width);
    endfunction

    function automatic logic in_range(input logic [63:0] addr, input int lsb, input int num_regs);
        return (addr >> lsb) < 64'(num_regs);
    endfunction
endpackage

// File: rtl/axil_if.sv
// axil_if: AXI4-Lite signal bundle with master/slave views
interface axil_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_regfile_wr_join.sv
// axil_regfile_wr_join: joins independent AW/W handshakes into one commit and owns the B channel
module axil_regfile_wr_join
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic                  bready,
    output logic                  bvalid,
    output logic [1:0]            bresp,
    output logic                  commit,
    output logic                  hit,
    output logic [ADDR_WIDTH-1:0] cmt_addr,
    output logic [DATA_WIDTH-1:0] cmt_data,
    output logic [STRB_WIDTH-1:0] cmt_strb
);
    localparam int ADDR_LSB = addr_lsb(STRB_WIDTH);

    logic                  aw_full, w_full, b_free, aw_hs, w_hs;
    logic [ADDR_WIDTH-1:0] aw_q;
    logic [DATA_WIDTH-1:0] w_q;
    logic [STRB_WIDTH-1:0] s_q;

    // A slot only opens once any pending response has been (or is being) taken.
    assign b_free   = !bvalid || bready;
    assign awready  = rst && !aw_full && b_free;
    assign wready   = rst && !w_full && b_free;
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign commit   = (aw_full || aw_hs) && (w_full || w_hs) && b_free;
    assign cmt_addr = aw_full ? aw_q : awaddr;
    assign cmt_data = w_full ? w_q : wdata;
    assign cmt_strb = w_full ? s_q : wstrb;
    assign hit      = in_range(64'(cmt_addr), ADDR_LSB, NUM_REGS);

    // Hold whichever half arrives first; commit launches the response and frees both slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            aw_q    <= '0;
            w_q     <= '0;
            s_q     <= '0;
        end else if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= hit ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_q    <= awaddr;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_q    <= wdata;
                s_q    <= wstrb;
            end
            if (bready) bvalid <= 1'b0;
        end
    end
endmodule

// File: rtl/axil_regfile.sv
// axil_regfile: AXI4-Lite slave register file with exported contents and write pulses
module axil_regfile
    import axil_pkg::*;
#(
    parameter int                      DATA_WIDTH  = 32,
    parameter int                      ADDR_WIDTH  = 32,
    parameter int                      STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int                      NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    axil_if.slave                          s_axil,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int ADDR_LSB = addr_lsb(STRB_WIDTH);
    localparam int IW       = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  commit, hit, ar_hs, rd_ok, unused;
    logic [ADDR_WIDTH-1:0] cmt_addr;
    logic [DATA_WIDTH-1:0] cmt_data;
    logic [STRB_WIDTH-1:0] cmt_strb;
    logic [NUM_REGS-1:0]   wr_hit;
    logic [IW-1:0]         w_idx, rd_idx;

    axil_regfile_wr_join #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .STRB_WIDTH(STRB_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_wr_join (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (s_axil.awaddr),
        .awvalid (s_axil.awvalid),
        .awready (s_axil.awready),
        .wdata   (s_axil.wdata),
        .wstrb   (s_axil.wstrb),
        .wvalid  (s_axil.wvalid),
        .wready  (s_axil.wready),
        .bready  (s_axil.bready),
        .bvalid  (s_axil.bvalid),
        .bresp   (s_axil.bresp),
        .commit  (commit),
        .hit     (hit),
        .cmt_addr(cmt_addr),
        .cmt_data(cmt_data),
        .cmt_strb(cmt_strb)
    );

    assign unused         = ^{s_axil.awprot, s_axil.arprot};
    assign w_idx          = IW'(cmt_addr >> ADDR_LSB);
    assign wr_hit         = (commit && hit) ? NUM_REGS'(1) << w_idx : '0;
    assign s_axil.arready = rst && (!s_axil.rvalid || s_axil.rready);
    assign ar_hs          = s_axil.arvalid && s_axil.arready;
    assign rd_ok          = in_range(64'(s_axil.araddr), ADDR_LSB, NUM_REGS);
    assign rd_idx         = IW'(s_axil.araddr >> ADDR_LSB);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

    // Byte-strobed register update and one-cycle write pulse for the committed index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= wr_hit;
            for (int i = 0; i < NUM_REGS; i++)
                for (int k = 0; k < STRB_WIDTH; k++)
                    if (wr_hit[i] && cmt_strb[k]) regs[i][8*k +: 8] <= cmt_data[8*k +: 8];
        end
    end

    // R channel: load on AR handshake (pre-write contents), hold until rready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_axil.rvalid <= 1'b0;
            s_axil.rdata  <= '0;
            s_axil.rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axil.rvalid <= 1'b1;
            s_axil.rdata  <= rd_ok ? regs[rd_idx] : '0;
            s_axil.rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axil.rready) begin
            s_axil.rvalid <= 1'b0;
        end
    end
endmodule
